// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between core and aux requesters with fixed-latency sequencing.
// Define DMEM_ARB_PERF_EN to add saturating stall_cycles / conflict_count counters.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [1:0]        core_mode,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [1:0]        aux_mode,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_mode,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       conflict_count
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
  state_t state, nxt;
  logic [3:0] cnt;
  logic last_aux, grant, sel_aux;
  always_comb begin
    grant = (state == IDLE) && (core_req || aux_req);
    // aux wins only when alone or when core was served last
    sel_aux = aux_req && (!core_req || !last_aux);
    nxt = (state == IDLE) ? (grant ? BUSY : IDLE) :
          (state == BUSY) ? ((cnt == 4'd0) ? RESP : BUSY) : IDLE;
  end
  assign core_stall = core_req & ~core_ack;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_aux   <= 1'b1;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_mode   <= '0;
      core_ack   <= 1'b0;
      aux_ack    <= 1'b0;
      core_rdata <= '0;
      aux_rdata  <= '0;
    end else begin
      state    <= nxt;
      core_ack <= 1'b0;
      aux_ack  <= 1'b0;
      if (grant) begin
        mem_en    <= 1'b1;
        mem_we    <= sel_aux ? aux_we : core_we;
        mem_addr  <= sel_aux ? aux_addr : core_addr;
        mem_wdata <= sel_aux ? aux_wdata : core_wdata;
        mem_mode  <= sel_aux ? aux_mode : core_mode;
        cnt       <= CNT_INIT;
        last_aux  <= sel_aux;
      end else if (state == BUSY) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (last_aux) begin
            aux_ack   <= 1'b1;
            aux_rdata <= mem_we ? '0 : mem_rdata;
          end else begin
            core_ack   <= 1'b1;
            core_rdata <= mem_we ? '0 : mem_rdata;
          end
        end
      end
    end
  end
`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cycles   <= '0;
      conflict_count <= '0;
    end else begin
      if (core_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
      if (state == IDLE && core_req && aux_req && !(&conflict_count)) conflict_count <= conflict_count + 16'd1;
    end
  end
`endif
endmodule
